pwm_deadtime_driver: RTL and testbench
======================================

PWM_DEADTIME_DRIVER -- requirements
Module: pwm_deadtime_driver

Interface
REQ-001 SHALL have parameter DT_W, default 8, dead-time counter/input width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  run request; low forces IDLE.
REQ-005 SHALL have port control_signal  input  16  PID output, two's-complement signed duty request in counter ticks.
REQ-006 SHALL have port ctrl_valid  input  1  one-cycle strobe qualifying control_signal.
REQ-007 SHALL have port period  input  16  PWM period in clk cycles, unsigned.
REQ-008 SHALL have port deadtime  input  DT_W  dead-time in clk cycles, unsigned.
REQ-009 SHALL have port pwm_hi  output  1  high-side gate drive, registered.
REQ-010 SHALL have port pwm_lo  output  1  low-side gate drive, registered.
REQ-011 SHALL have port period_start  output  1  one-cycle pulse in every cycle where counter equals 0 while running.
REQ-012 SHALL have port duty_active  output  16  duty currently in effect.
REQ-013 SHALL have port sat_flag  output  1  last captured request was clamped.

Function
REQ-014 Clamp on capture: control_signal < 0 -> 0; control_signal > period (unsigned compare) -> period; else unchanged; sat_flag <= 1 if clamped, else 0.
REQ-015 ctrl_valid high at edge N SHALL write clamped value into duty shadow at edge N; no effect on duty_active until next period boundary.
REQ-016 Period boundary = edge where counter wraps from period_active-1 to 0; at that edge duty_active <= duty shadow, period_active <= period input.
REQ-017 Simultaneous ctrl_valid and boundary: duty_active takes shadow value held before that edge; new value waits one period.
REQ-018 Counter SHALL count 0..period_active-1 while running; raw = (counter < duty_active).
REQ-019 duty_active = 0 -> raw constantly 0; duty_active >= period_active -> raw constantly 1 (100%).
REQ-020 FSM states: IDLE, HI_ON, DEAD_TO_LO, LO_ON, DEAD_TO_HI; pwm_hi = 1 only in HI_ON, pwm_lo = 1 only in LO_ON; both never high together.
REQ-021 IDLE -> (enable and period != 0): load period_active, duty_active from shadow/inputs, counter <= 0, enter DEAD_TO_HI if raw=1 else DEAD_TO_LO.
REQ-022 HI_ON -> DEAD_TO_LO when raw=0; LO_ON -> DEAD_TO_HI when raw=1; dead counter loaded with deadtime on entry.
REQ-023 Dead states hold both outputs low for exactly deadtime cycles, then enter HI_ON if raw=1 else LO_ON (raw sampled at expiry).
REQ-024 deadtime = 0: dead states bypassed; HI_ON<->LO_ON switch in one edge.
REQ-025 Output latency: raw change at cycle k -> gate change at edge k+1 (deadtime=0) or k+1+deadtime.
REQ-026 enable low at any edge: next state IDLE, outputs low, counter <= 0, period_start low; shadow capture continues.
REQ-027 Boundary with period input = 0: enter IDLE until enable cycle with period != 0.
REQ-028 deadtime input SHALL be sampled only on dead-state entry; changes mid-dead-time ignored.

Reset
REQ-029 rst_n low SHALL immediately force pwm_hi=0, pwm_lo=0, period_start=0, duty_active=0, sat_flag=0, counter=0, shadows=0, state IDLE.
REQ-030 After rst_n release, block SHALL remain IDLE until enable high with nonzero period.
REQ-031 Reset asserted mid-period or mid-dead-time SHALL abort without glitching either output high.

Verification
REQ-032 period=100, deadtime=5, ctrl_valid with 40, enable -> after first boundary pwm_hi high 35 cycles, both low 5, pwm_lo 55, both low 5, repeating; period_start every 100 cycles.
REQ-033 control_signal=0xFF00 (-256) -> duty 0, sat_flag=1, pwm_lo continuously high; control_signal=500, period=100 -> duty 100, sat_flag=1, pwm_hi continuously high.
REQ-034 ctrl_valid 60 on same edge as boundary while duty_active=40 -> period uses 40, next period 60.
REQ-035 deadtime=0, duty 50/period 100 -> hi/lo complementary, never both high, never both low after start-up.
REQ-036 rst_n low during DEAD_TO_HI and enable drop during HI_ON -> outputs low same/next edge; assertion pwm_hi&pwm_lo never true.

Source files
------------

// File: rtl/pwm_deadtime_driver.sv
// pwm_deadtime_driver
// Centre-less (edge-aligned) PWM generator with complementary high/low gate
// drives and programmable dead time between them.
//
// Handshake: ctrl_valid is a one-cycle strobe with no back-pressure (there is
// no ready). Every cycle ctrl_valid is high, control_signal is clamped against
// the current period input and written into the duty shadow at that edge.
// The shadow only reaches duty_active at the next period boundary, so a
// running period never changes its duty part-way through.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   enable         run request; low returns the block to IDLE with gates off
//   control_signal signed duty request in counter ticks (two's complement)
//   ctrl_valid     one-cycle strobe qualifying control_signal
//   period         PWM period in clk cycles, taken at start and each boundary
//   deadtime       dead time in clk cycles, taken on each dead-state entry
//   pwm_hi         high-side gate drive (registered)
//   pwm_lo         low-side gate drive (registered)
//   period_start   high in every running cycle whose counter value is 0
//   duty_active    duty in effect for the current period
//   sat_flag       the last captured request was clamped
//   state_dbg      current gate FSM state, for observation only
module pwm_deadtime_driver #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [15:0]     control_signal,
  input  logic            ctrl_valid,
  input  logic [15:0]     period,
  input  logic [DT_W-1:0] deadtime,
  output logic            pwm_hi,
  output logic            pwm_lo,
  output logic            period_start,
  output logic [15:0]     duty_active,
  output logic            sat_flag,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HI_ON      = 3'd1,
    DEAD_TO_LO = 3'd2,
    LO_ON      = 3'd3,
    DEAD_TO_HI = 3'd4
  } state_t;

  state_t          state;
  logic [15:0]     counter;
  logic [15:0]     period_active;
  logic [15:0]     duty_shadow;
  logic [DT_W-1:0] dead_cnt;

  logic        raw;
  logic        boundary;
  logic        start_raw;
  logic        dead_zero;
  logic        ctrl_neg;
  logic        ctrl_over;
  logic [15:0] ctrl_clamped;

  // duty_active >= period_active makes raw stay 1 for the whole period, and
  // duty_active == 0 makes it stay 0, with no special casing needed.
  assign raw       = (counter < duty_active);
  // period_active is never 0 while running, so the subtraction cannot wrap.
  assign boundary  = (counter == (period_active - 16'd1));
  // At start the counter restarts at 0 with duty_active taken from the
  // shadow, so the first raw value is simply "shadow is nonzero".
  assign start_raw = (duty_shadow != 16'd0);
  assign dead_zero = (deadtime == '0);

  assign ctrl_neg     = control_signal[15];
  assign ctrl_over    = !ctrl_neg && (control_signal > period);
  assign ctrl_clamped = ctrl_neg  ? 16'd0 :
                        ctrl_over ? period : control_signal;

  assign state_dbg = state;

  // Shadow capture runs regardless of enable or FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= 16'd0;
      sat_flag    <= 1'b0;
    end else if (ctrl_valid) begin
      duty_shadow <= ctrl_clamped;
      sat_flag    <= ctrl_neg || ctrl_over;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= 16'd0;
      period_active <= 16'd0;
      duty_active   <= 16'd0;
      dead_cnt      <= '0;
      pwm_hi        <= 1'b0;
      pwm_lo        <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      period_start <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        counter <= 16'd0;
        pwm_hi  <= 1'b0;
        pwm_lo  <= 1'b0;
      end else if (state == IDLE) begin
        if (period != 16'd0) begin
          period_active <= period;
          duty_active   <= duty_shadow;
          counter       <= 16'd0;
          period_start  <= 1'b1;
          if (dead_zero) begin
            state  <= start_raw ? HI_ON : LO_ON;
            pwm_hi <= start_raw;
            pwm_lo <= !start_raw;
          end else begin
            // Both gates stay off for a full dead time out of IDLE, so a
            // restart never turns a gate on straight away.
            state    <= start_raw ? DEAD_TO_HI : DEAD_TO_LO;
            dead_cnt <= deadtime;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
          end
        end
      end else begin
        if (boundary) begin
          duty_active   <= duty_shadow;
          period_active <= period;
          counter       <= 16'd0;
        end else begin
          counter <= counter + 16'd1;
        end

        if (boundary && (period == 16'd0)) begin
          state  <= IDLE;
          pwm_hi <= 1'b0;
          pwm_lo <= 1'b0;
        end else begin
          period_start <= boundary;
          case (state)
            HI_ON: begin
              if (!raw) begin
                pwm_hi <= 1'b0;
                if (dead_zero) begin
                  state  <= LO_ON;
                  pwm_lo <= 1'b1;
                end else begin
                  state    <= DEAD_TO_LO;
                  dead_cnt <= deadtime;
                end
              end
            end
            LO_ON: begin
              if (raw) begin
                pwm_lo <= 1'b0;
                if (dead_zero) begin
                  state  <= HI_ON;
                  pwm_hi <= 1'b1;
                end else begin
                  state    <= DEAD_TO_HI;
                  dead_cnt <= deadtime;
                end
              end
            end
            DEAD_TO_LO, DEAD_TO_HI: begin
              // dead_cnt counts the remaining dead cycles including this one;
              // the gate choice uses raw as it stands at expiry.
              if (dead_cnt <= DT_W'(1)) begin
                state  <= raw ? HI_ON : LO_ON;
                pwm_hi <= raw;
                pwm_lo <= !raw;
              end else begin
                dead_cnt <= dead_cnt - DT_W'(1);
              end
            end
            default: begin
              state  <= IDLE;
              pwm_hi <= 1'b0;
              pwm_lo <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Testbench for pwm_deadtime_driver.
// The reference model tracks the PWM schedule (position in period, duty in
// effect, shadow) and a history of the ideal raw comparison per cycle. A gate
// is expected on only when its raw level has held for deadtime+1 consecutive
// running cycles; stimulus keeps every raw segment longer than the dead time
// so that rule describes the full gate behaviour.
module tb_pwm_deadtime_driver;
  localparam int DT_W = 8;
  localparam int EW   = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [15:0]     control_signal;
  logic            ctrl_valid;
  logic [15:0]     period;
  logic [DT_W-1:0] deadtime;
  logic            pwm_hi;
  logic            pwm_lo;
  logic            period_start;
  logic [15:0]     duty_active;
  logic            sat_flag;
  logic [2:0]      state_dbg;

  pwm_deadtime_driver #(.DT_W(DT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .control_signal(control_signal), .ctrl_valid(ctrl_valid),
    .period(period), .deadtime(deadtime),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start),
    .duty_active(duty_active), .sat_flag(sat_flag), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  // reference model state (values in effect after the most recent edge)
  bit m_run    = 0;
  int m_cnt    = 0;
  int m_per    = 0;
  int m_duty   = 0;
  int m_shadow = 0;
  bit m_sat    = 0;
  int hist[$];  // ideal raw per cycle: 0, 1, or 2 when not running

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver + model ----------------
  task automatic step(input bit en, input bit cv, input logic [15:0] cs,
                      input logic [15:0] per, input int dt);
    int r;
    int cs_i;
    int idx;
    bit ps_e;
    bit hi_e;
    bit lo_e;
    @(negedge clk);
    enable         = en;
    ctrl_valid     = cv;
    control_signal = cs;
    period         = per;
    deadtime       = DT_W'(dt);
    ps_e = 0;
    if (!en) begin
      r = 2;
      m_run = 0;
      m_cnt = 0;
    end else if (!m_run) begin
      if (per != 16'd0) begin
        r = (m_shadow != 0) ? 1 : 0;
        m_run = 1; m_cnt = 0; m_per = int'(per); m_duty = m_shadow; ps_e = 1;
      end else begin
        r = 2;
      end
    end else begin
      r = (m_cnt < m_duty) ? 1 : 0;
      if (m_cnt == m_per - 1) begin
        m_duty = m_shadow;
        m_per  = int'(per);
        m_cnt  = 0;
        if (per == 16'd0) begin
          m_run = 0;
          r = 2;
        end else begin
          ps_e = 1;
        end
      end else begin
        m_cnt++;
      end
    end
    if (cv) begin
      cs_i = int'($signed(cs));
      if (cs_i < 0) begin
        m_shadow = 0; m_sat = 1;
      end else if (cs_i > int'(per)) begin
        m_shadow = int'(per); m_sat = 1;
      end else begin
        m_shadow = cs_i; m_sat = 0;
      end
    end
    hist.push_back(r);
    if (hist.size() > 64) void'(hist.pop_front());
    hi_e = 1;
    lo_e = 1;
    for (int k = 0; k <= dt; k++) begin
      idx = hist.size() - 1 - k;
      if (idx < 0) begin
        hi_e = 0; lo_e = 0;
      end else begin
        if (hist[idx] != 1) hi_e = 0;
        if (hist[idx] != 0) lo_e = 0;
      end
    end
    exp_q.push_back({hi_e, lo_e, ps_e, m_sat, 16'(m_duty)});
  endtask

  function automatic logic [15:0] gen_ctrl(input int p, input int dt);
    int v;
    case ($urandom_range(0, 5))
      0:       v = -int'($urandom_range(1, 30000));
      1:       v = p + int'($urandom_range(1, 1000));
      2:       v = p;
      3:       v = 0;
      default: v = int'($urandom_range(dt + 2, p - dt - 2));
    endcase
    return 16'(v);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      chk("gates_overlap", {31'd0, pwm_hi & pwm_lo}, 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hi_lo_ps_sat_duty", {12'd0, pwm_hi, pwm_lo, period_start, sat_flag, duty_active},
            {12'd0, e});
      end
    end
  end

  // ---------------- stimulus ----------------
  int ph_p[10]    = '{100, 100, 100, 100, 100, 0, 0, 0, 0, 0};
  int ph_dt[10]   = '{5, 5, 5, 0, 5, 0, 0, 0, 0, 0};
  int ph_init[10] = '{40, -256, 500, 50, 40, 0, 0, 0, 0, 0};
  bit ph_rnd[10]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    int p, dt, len, off_cnt, zero_lo, zero_hi;
    bit en, cv;
    bit found;
    logic [15:0] cs, per_in;

    rst_n = 1'b0; enable = 1'b0; control_signal = 16'd0; ctrl_valid = 1'b0;
    period = 16'd0; deadtime = '0;
    #3;
    chk("reset_pwm_hi", {31'd0, pwm_hi}, 32'd0);
    chk("reset_pwm_lo", {31'd0, pwm_lo}, 32'd0);
    chk("reset_period_start", {31'd0, period_start}, 32'd0);
    chk("reset_duty_active", {16'd0, duty_active}, 32'd0);
    chk("reset_sat_flag", {31'd0, sat_flag}, 32'd0);
    chk("reset_state", {29'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // enabled with a zero period must stay idle
    for (int i = 0; i < 4; i++) step(1, 0, 16'd0, 16'd0, 3);

    for (int ph = 0; ph < 10; ph++) begin
      if (ph_rnd[ph] && ph >= 5) begin
        dt = int'($urandom_range(0, 6));
        p  = int'($urandom_range(2 * dt + 6, 60));
        cs = gen_ctrl(p, dt);
      end else begin
        dt = ph_dt[ph];
        p  = ph_p[ph];
        cs = 16'(ph_init[ph]);
      end
      step(0, 1, cs, 16'(p), dt);
      step(0, 0, 16'd0, 16'(p), dt);
      len     = 5 * p + 100;
      off_cnt = 0;
      zero_lo = (ph == 6) ? len / 3 : len + 1;
      zero_hi = zero_lo + 2 * p;
      for (int c = 0; c < len; c++) begin
        per_in = (c >= zero_lo && c < zero_hi) ? 16'd0 : 16'(p);
        if (ph_rnd[ph] && off_cnt == 0 && $urandom_range(0, 299) == 0)
          off_cnt = int'($urandom_range(1, 3));
        en = (off_cnt == 0);
        if (off_cnt > 0) off_cnt--;
        cv = 0;
        if (ph_rnd[ph] && per_in != 16'd0) begin
          if ($urandom_range(0, 15) == 0) cv = 1;
          if (m_run && m_cnt == m_per - 1 && $urandom_range(0, 1) == 0) cv = 1;
        end
        cs = cv ? gen_ctrl(p, dt) : 16'd0;
        step(en, cv, cs, per_in, dt);
      end
      step(0, 0, 16'd0, 16'(p), dt);
    end

    // drain the scoreboard
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d entries required=0", exp_q.size());
    end

    // reset in the middle of a dead time
    @(negedge clk);
    enable = 1'b0; ctrl_valid = 1'b1; control_signal = 16'd10; period = 16'd20; deadtime = 8'd4;
    @(negedge clk);
    ctrl_valid = 1'b0; enable = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd4) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_dead_to_hi actual=%0d required=4", state_dbg);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_pwm_hi", {31'd0, pwm_hi}, 32'd0);
    chk("midreset_pwm_lo", {31'd0, pwm_lo}, 32'd0);
    chk("midreset_period_start", {31'd0, period_start}, 32'd0);
    chk("midreset_duty_active", {16'd0, duty_active}, 32'd0);
    chk("midreset_sat_flag", {31'd0, sat_flag}, 32'd0);
    chk("midreset_state", {29'd0, state_dbg}, 32'd0);

    // enable drop while the high side is on
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0; ctrl_valid = 1'b1; control_signal = 16'd10;
    @(negedge clk);
    ctrl_valid = 1'b0; enable = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_hi_on actual=%0d required=1", state_dbg);
    end
    chk("hi_on_gate", {31'd0, pwm_hi}, 32'd1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("disable_pwm_hi", {31'd0, pwm_hi}, 32'd0);
    chk("disable_pwm_lo", {31'd0, pwm_lo}, 32'd0);
    chk("disable_period_start", {31'd0, period_start}, 32'd0);
    chk("disable_state", {29'd0, state_dbg}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
